// File: rtl/rv32.sv
// Shared RV32 datapath types: XLEN word, register index, writeback arbiter state.
// Pure type/constant package; no logic, no latency, no flow control.
package rv32;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [XLEN-1:0]           word;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef enum logic {
    LD_FIRST = 1'b0,
    EX_FIRST = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: execute and load requests onto one register-file write port, 1-cycle registered latency.
// Backpressure: combinational ready; losing requester holds, execute promoted after STARVE_LIMIT consecutive losses.
module rf_wb_arbiter
  import rv32::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ex_valid,
  output logic      ex_ready,
  input  reg_addr_t ex_rd,
  input  word       ex_data,
  input  logic      ld_valid,
  output logic      ld_ready,
  input  reg_addr_t ld_rd,
  input  word       ld_data,
  output logic      rf_we,
  output reg_addr_t rf_waddr,
  output word       rf_wdata,
  output logic      ex_promoted
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  wb_arb_state_t state;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_nxt;

  logic ex_cont;
  logic ld_cont;
  logic ex_grant;
  logic ld_grant;

  // Writes to x0 are absorbed here and never compete for the write port.
  always_comb begin
    ex_cont  = ex_valid && (ex_rd != '0);
    ld_cont  = ld_valid && (ld_rd != '0);
    ex_grant = !rst && ex_cont && (!ld_cont || (state == EX_FIRST));
    ld_grant = !rst && ld_cont && (!ex_cont || (state == LD_FIRST));
    ex_ready = !rst && ex_valid && ((ex_rd == '0) || ex_grant);
    ld_ready = !rst && ld_valid && ((ld_rd == '0) || ld_grant);

    starve_cnt_nxt = '0;
    if (ex_cont && !ex_grant) begin
      starve_cnt_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_FIRST;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      case (state)
        LD_FIRST: if (starve_cnt_nxt == LIMIT) state <= EX_FIRST;
        EX_FIRST: if (!ex_valid || ex_ready)   state <= LD_FIRST;
        default:                               state <= LD_FIRST;
      endcase
    end
  end

  // Address/data hold their last value when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (ex_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= ex_rd;
      rf_wdata <= ex_data;
    end else if (ld_grant) begin
      rf_we    <= 1'b1;
      rf_waddr <= ld_rd;
      rf_wdata <= ld_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign ex_promoted = (state == EX_FIRST);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes queued at grant, checked one cycle later.
module tb_rf_wb_arbiter;
  import rv32::*;

  typedef struct packed {
    reg_addr_t a;
    word       d;
  } wr_t;

  logic      clk = 1'b0;
  logic      rst;
  logic      ex_valid, ex_ready, ld_valid, ld_ready;
  reg_addr_t ex_rd, ld_rd;
  word       ex_data, ld_data;
  logic      rf_we, ex_promoted;
  reg_addr_t rf_waddr;
  word       rf_wdata;

  int        checks   = 0;
  int        failures = 0;
  wr_t       exp_q[$];
  reg_addr_t last_a;
  word       last_d;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ex_promoted(ex_promoted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check readies/promotion, queue the expected write, then check the output port.
  task automatic step(input string tag, input logic r,
                      input logic ev, input reg_addr_t erd, input word ed,
                      input logic lv, input reg_addr_t lrd, input word ldd,
                      input logic x_er, input logic x_lr, input logic x_prom);
    wr_t e;
    @(negedge clk);
    rst = r;
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    #1;
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(x_er));
    chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(x_lr));
    chk({tag, ".ex_promoted"}, 32'(ex_promoted), 32'(x_prom));
    if (x_er && erd != '0) exp_q.push_back('{a: erd, d: ed});
    if (x_lr && lrd != '0) exp_q.push_back('{a: lrd, d: ldd});
    if (r) begin
      exp_q.delete();
      last_a = '0;
      last_d = '0;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_a = e.a;
      last_d = e.d;
      chk({tag, ".rf_we"}, 32'(rf_we), 32'd1);
    end else begin
      chk({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    end
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(last_a));
    chk({tag, ".rf_wdata"}, rf_wdata, last_d);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    last_a = '0; last_d = '0;

    step("reset0", 1, 0, 0, 0,            0, 0, 0,            0, 0, 0);
    step("reset1", 1, 1, 2, 32'h1,        1, 3, 32'h2,        0, 0, 0);

    // Single execute request
    step("ex_only", 0, 1, 5, 32'h0000_1234, 0, 0, 0,          1, 0, 0);
    step("idle0",   0, 0, 0, 0,            0, 0, 0,            0, 0, 0);

    // x0 on one side, contending grant on the other
    step("ex_x0",   0, 1, 0, 32'hDEAD_BEEF, 1, 7, 32'h0000_0777, 1, 1, 0);
    step("ld_x0",   0, 1, 6, 32'h0000_0666, 1, 0, 32'hCAFE_F00D, 1, 1, 0);
    step("idle1",   0, 0, 0, 0,            0, 0, 0,            0, 0, 0);

    // Same destination: ld first, then ex; ex data is final
    step("same_rd_a", 0, 1, 9, 32'hAAAA_AAAA, 1, 9, 32'h5555_5555, 0, 1, 0);
    step("same_rd_b", 0, 1, 9, 32'hAAAA_AAAA, 0, 0, 0,            1, 0, 0);
    step("same_rd_hold", 0, 0, 0, 0,         0, 0, 0,            0, 0, 0);

    // Starvation: four ld wins, promotion, ex wins, ld resumes
    for (int i = 0; i < 4; i++)
      step("starve_ld", 0, 1, 3, 32'h0000_0300, 1, 4, 32'h0000_0400 + 32'(i), 0, 1, 0);
    step("starve_ex",   0, 1, 3, 32'h0000_0300, 1, 4, 32'h0000_0404, 1, 0, 1);
    step("starve_back", 0, 1, 3, 32'h0000_0301, 1, 4, 32'h0000_0404, 0, 1, 0);
    step("idle2",       0, 0, 0, 0,            0, 0, 0,            0, 0, 0);

    // Dropping ex_valid clears the count: four fresh losses needed
    step("drop_l1", 0, 1, 3, 32'h31, 1, 4, 32'h41, 0, 1, 0);
    step("drop_l2", 0, 1, 3, 32'h31, 1, 4, 32'h42, 0, 1, 0);
    step("drop_gap", 0, 0, 0, 0,     1, 4, 32'h43, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step("drop_fresh", 0, 1, 3, 32'h32, 1, 4, 32'h50 + 32'(i), 0, 1, 0);
    step("drop_ex",   0, 1, 3, 32'h32, 1, 4, 32'h54, 1, 0, 1);
    step("drop_back", 0, 0, 0, 0,      1, 4, 32'h54, 0, 1, 0);

    // Reset right after a grant, while promoted; state must return to LD_FIRST
    for (int i = 0; i < 4; i++)
      step("rst_pre", 0, 1, 3, 32'h60, 1, 4, 32'h70 + 32'(i), 0, 1, 0);
    step("rst_mid",  1, 1, 3, 32'h60, 1, 4, 32'h74, 0, 0, 1);
    step("rst_post", 0, 1, 3, 32'h60, 1, 4, 32'h74, 0, 1, 0);
    step("idle3",    0, 0, 0, 0,      0, 0, 0,      0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost contention cycles after which the execute requester is promoted.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports ex_valid (input, 1), ex_ready (output, 1), ex_rd (input, reg_addr_t), ex_data (input, word): execute-unit writeback request.
REQ-005 SHALL have ports ld_valid (input, 1), ld_ready (output, 1), ld_rd (input, reg_addr_t), ld_data (input, word): load-unit writeback request.
REQ-006 SHALL have ports rf_we (output, 1), rf_waddr (output, reg_addr_t), rf_wdata (output, word): single register-file write port, registered.
REQ-007 SHALL have port ex_promoted (output, 1): high while the arbiter is in state EX_FIRST.

Function
REQ-008 SHALL complete a transfer on a requester in any cycle where its valid and ready are both high.
REQ-009 SHALL drive ex_ready and ld_ready combinationally from current valid, rd and state; neither depends on the other's ready.
REQ-010 SHALL require requesters to hold valid, rd and data stable until transfer; the arbiter never drops a held request.
REQ-011 SHALL accept any request with rd = 0 immediately (ready = 1 whenever valid), consume no write slot, and produce no rf_we pulse.
REQ-012 SHALL treat a request with rd != 0 as contending; at most one contending request transfers per cycle.
REQ-013 SHALL, with exactly one contending request, grant it in the same cycle.
REQ-014 SHALL, with both contending, grant ld in state LD_FIRST and ex in state EX_FIRST.
REQ-015 SHALL present a granted contending transfer on rf_we/rf_waddr/rf_wdata at the next rising edge (latency 1), rf_we high for exactly one cycle per transfer.
REQ-016 SHALL deassert rf_we in any cycle following no contending transfer; rf_waddr/rf_wdata hold their last values.
REQ-017 SHALL keep a starvation counter of width $clog2(STARVE_LIMIT+1): increment (saturating at STARVE_LIMIT) each cycle ex contends and loses; clear when ex transfers or ex_valid is low.
REQ-018 SHALL implement a two-state FSM: LD_FIRST -> EX_FIRST when the counter's next value equals STARVE_LIMIT; EX_FIRST -> LD_FIRST on the cycle ex transfers or ex_valid drops; otherwise hold.
REQ-019 SHALL, when both requests target the same nonzero rd, write them in grant order on successive cycles; the later grant's data is final.
REQ-020 SHALL permit simultaneous x0 acceptance on one requester and contending grant on the other in the same cycle.

Reset
REQ-021 SHALL, on rst high at a rising edge, set rf_we = 0, rf_waddr = 0, rf_wdata = 0, counter = 0, state = LD_FIRST, ex_promoted = 0.
REQ-022 SHALL force ex_ready = 0 and ld_ready = 0 while rst is high; a transfer in flight to the output register is discarded.
REQ-023 SHALL resume normal arbitration on the first rising edge with rst low.

Structure
REQ-024 SHALL take word, reg_addr_t, XLEN and REG_ADDR_WIDTH from package rv32; no local redefinition.
REQ-025 SHALL declare the FSM state enum (LD_FIRST, EX_FIRST) in package rv32 as wb_arb_state_t for debug visibility.
REQ-026 SHALL be a single module with no sub-modules; the output register is internal.

Verification
REQ-027 SHALL cover: ex only, rd=5, data=0x0000_1234 -> ex_ready same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234.
REQ-028 SHALL cover: ex rd=3 and ld rd=4 both held, STARVE_LIMIT=4 -> ld wins cycles 0-3, ex_promoted high after cycle 3, ex wins cycle 4, then ld resumes priority.
REQ-029 SHALL cover: ex rd=0 and ld rd=7 same cycle -> both ready same cycle; only one rf_we pulse, rf_waddr=7.
REQ-030 SHALL cover: ex and ld both rd=9 (ex 0xAAAA_AAAA, ld 0x5555_5555), LD_FIRST -> two consecutive writes, ld then ex; final rf_wdata 0xAAAA_AAAA.
REQ-031 SHALL cover: rst asserted the cycle after a grant -> rf_we=0 next edge, both readies low during reset, state LD_FIRST afterwards.
REQ-032 SHALL cover: ex contends 2 cycles, drops ex_valid 1 cycle, re-asserts -> counter restarts at 0; promotion needs 4 fresh losses.
